// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter datapath and its Y-sample readout stage.
package fir_pkg;

  // Readout FSM states; values fixed so waveforms stay readable across revisions.
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    HDR0  = 4'd1,
    HDR1  = 4'd2,
    RADDR = 4'd3,
    RLAT  = 4'd4,
    SLO   = 4'd5,
    SHI   = 4'd6,
    NEXT  = 4'd7,
    FIN   = 4'd8
  } dump_state_t;

  // Two-byte sync header that opens every dump.
  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  // Number of Y-samples; the filter FSM's write-address limit uses this too.
  localparam int unsigned DEF_N_SAMPLES = 172;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter. Accepts a byte whenever tx_ready is high; tx_ready
// also rises in the final stop-bit cycle so frames can be chained with no gap.
module uart_tx_byte #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       txd
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [9:0]       shift_q;
  logic [CNT_W-1:0] baud_q;
  logic [3:0]       bit_q;
  logic             active_q;
  logic             baud_end;
  logic             last_bit;

  assign baud_end = (baud_q == CNT_W'(CLK_DIV - 1));
  assign last_bit = (bit_q == 4'd9);
  assign tx_ready = ~active_q | (baud_end & last_bit);
  // Shift register idles all-ones, so the line rests high between frames.
  assign txd      = shift_q[0];

  // Frame sequencing: a load wins over the final stop-bit shift to chain frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else if (tx_load && tx_ready) begin
      shift_q  <= {1'b1, tx_byte, 1'b0};
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (baud_end) begin
        baud_q  <= '0;
        shift_q <= {1'b1, shift_q[9:1]};
        bit_q   <= bit_q + 4'd1;
        if (last_bit) begin
          active_q <= 1'b0;
        end
      end else begin
        baud_q <= baud_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/y_dump_uart.sv
// Y-sample readout: on a rising start edge, sends A5 5A followed by every
// OUT_RAM sample (low byte first) over an 8N1 UART line.
module y_dump_uart
  import fir_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned N_SAMPLES = DEF_N_SAMPLES,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [15:0]       ram_data,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  dump_state_t       state_q;
  dump_state_t       state_d;
  logic              start_q;
  logic [ADDR_W-1:0] k_q;
  logic [ADDR_W-1:0] k_d;
  logic [15:0]       hold_q;
  logic              done_q;
  logic              tx_load;
  logic              tx_ready;
  logic [7:0]        tx_byte;
  logic              accept;
  logic              last_k;

  assign accept   = start & ~start_q;
  assign last_k   = (k_q == ADDR_W'(N_SAMPLES - 1));
  assign ram_addr = k_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  // Next-state, sample index and transmitter load decode.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    tx_load = 1'b0;
    tx_byte = SYNC0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HDR0;
          k_d     = '0;
        end
      end
      HDR0: begin
        tx_byte = SYNC0;
        if (tx_ready) begin
          tx_load = 1'b1;
          state_d = HDR1;
        end
      end
      HDR1: begin
        tx_byte = SYNC1;
        if (tx_ready) begin
          tx_load = 1'b1;
          state_d = RADDR;
        end
      end
      // RAM fetch runs while the previous byte is still on the line.
      RADDR: state_d = RLAT;
      RLAT:  state_d = SLO;
      SLO: begin
        tx_byte = hold_q[7:0];
        if (tx_ready) begin
          tx_load = 1'b1;
          state_d = SHI;
        end
      end
      SHI: begin
        tx_byte = hold_q[15:8];
        if (tx_ready) begin
          tx_load = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (last_k) begin
          state_d = FIN;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = RADDR;
        end
      end
      FIN: begin
        if (tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, edge detect, sample index, holding register and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      k_q     <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      k_q     <= k_d;
      done_q  <= (state_q == FIN) && tx_ready;
      if (state_q == RLAT) begin
        hold_q <= ram_data;
      end
    end
  end

  uart_tx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .tx_load  (tx_load),
    .tx_byte  (tx_byte),
    .tx_ready (tx_ready),
    .txd      (txd)
  );

endmodule

// File: tb/tb_y_dump_uart.sv
// Self-checking bench for y_dump_uart with CLK_DIV=4, N_SAMPLES=3.
module tb_y_dump_uart;

  localparam int CLK_DIV   = 4;
  localparam int N_SAMPLES = 3;
  localparam int ADDR_W    = 8;
  localparam int NBYTES    = 2 + 2 * N_SAMPLES;
  localparam int FRAME     = 10 * CLK_DIV;
  localparam int DONE_AT   = NBYTES * FRAME + 2;
  localparam int WIN       = DONE_AT + 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_data;
  logic              txd;
  logic              busy;
  logic              done;

  logic [15:0] mem [N_SAMPLES];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous-read RAM: data valid one cycle after the address.
  always @(posedge clk) begin
    if (int'(ram_addr) < N_SAMPLES) ram_data <= mem[ram_addr[1:0]];
    else ram_data <= 16'hDEAD;
  end

  y_dump_uart #(
    .CLK_DIV   (CLK_DIV),
    .N_SAMPLES (N_SAMPLES),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .txd      (txd),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [47:0] words;    // {w2, w1, w0}
    logic [47:0] payload;  // expected payload bytes, first byte in [47:40]
    int          mode;     // 0 pulse, 1 retrigger in byte 3, 2 hold level
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference payload: each sample low byte then high byte.
  function automatic logic [47:0] model_payload(input logic [47:0] words);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < N_SAMPLES; k++) begin
      r[47 - 16 * k -: 8] = words[16 * k +: 8];
      r[39 - 16 * k -: 8] = words[16 * k + 8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input logic [47:0] payload);
    if (i == 0) return 8'hA5;
    if (i == 1) return 8'h5A;
    return payload[47 - 8 * (i - 2) -: 8];
  endfunction

  // Expected line level over one frame: start 0, data LSB first, stop 1.
  function automatic logic [63:0] exp_frame(input logic [7:0] b);
    logic [9:0]  bits;
    logic [63:0] f;
    bits = {1'b1, b, 1'b0};
    f = '0;
    for (int p = 0; p < FRAME; p++) f[p] = bits[p / CLK_DIV];
    return f;
  endfunction

  task automatic do_dump(input vec_t v, input string tag);
    logic [WIN:0] tx_log;
    logic [WIN:0] done_log;
    logic [WIN:0] busy_log;
    logic         quiet;
    tx_log = '0;
    done_log = '0;
    busy_log = '0;
    for (int k = 0; k < N_SAMPLES; k++) mem[k] = v.words[16 * k +: 16];
    start = 1'b0;
    repeat (3) step();
    start = 1'b1;
    for (int n = 1; n <= WIN; n++) begin
      step();
      tx_log[n] = txd;
      done_log[n] = done;
      busy_log[n] = busy;
      if (v.mode == 0 && n == 5) start = 1'b0;
      if (v.mode == 1 && n == 90) start = 1'b0;
      if (v.mode == 1 && n == 100) start = 1'b1;
    end
    for (int i = 0; i < NBYTES; i++)
      check($sformatf("%s byte%0d", tag, i), 64'(tx_log[2 + i * FRAME +: FRAME]),
            exp_frame(exp_byte(i, v.payload)));
    check({tag, " done_count"}, 64'($countones(done_log)), 64'd1);
    check({tag, " done_cycle"}, 64'(done_log[DONE_AT]), 64'd1);
    check({tag, " busy_first"}, 64'(busy_log[1]), 64'd1);
    check({tag, " busy_last"}, 64'(busy_log[DONE_AT - 1]), 64'd1);
    check({tag, " busy_fall"}, 64'(busy_log[DONE_AT]), 64'd0);
    check({tag, " txd_pre"}, 64'(tx_log[1]), 64'd1);
    check({tag, " txd_idle"}, 64'(&tx_log[WIN:DONE_AT]), 64'd1);
    check({tag, " ram_addr_hold"}, 64'(ram_addr), 64'(N_SAMPLES - 1));
    quiet = 1'b1;
    repeat (30) begin
      step();
      if (busy || done || !txd) quiet = 1'b0;
    end
    check({tag, " no_extra_dump"}, 64'(quiet), 64'd1);
  endtask

  vec_t vecs [5];
  vec_t rv;
  logic quiet;

  initial begin
    vecs[0] = '{words: 48'h8000_FFFF_1234, payload: 48'h3412_FFFF_0080, mode: 0};
    vecs[1] = '{words: 48'h8000_FFFF_1234, payload: 48'h3412_FFFF_0080, mode: 1};
    vecs[2] = '{words: 48'h8000_FFFF_1234, payload: 48'h3412_FFFF_0080, mode: 0};
    vecs[3] = '{words: 48'hA55A_00FF_0000, payload: 48'h0000_FF00_5AA5, mode: 2};
    vecs[4] = '{words: 48'h7FFE_8000_0001, payload: 48'h0100_0080_FE7F, mode: 0};

    reset = 1'b1;
    start = 1'b0;
    for (int k = 0; k < N_SAMPLES; k++) mem[k] = '0;
    repeat (3) step();
    check("reset txd", 64'(txd), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset ram_addr", 64'(ram_addr), 64'd0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) do_dump(vecs[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 4; r++) begin
      rv.words = {16'($urandom), 16'($urandom), 16'($urandom)};
      rv.payload = model_payload(rv.words);
      rv.mode = int'($urandom_range(0, 2));
      do_dump(rv, $sformatf("rand%0d", r));
    end

    // Reset during a data bit of byte 5 abandons the frame.
    for (int k = 0; k < N_SAMPLES; k++) mem[k] = vecs[0].words[16 * k +: 16];
    start = 1'b0;
    repeat (3) step();
    start = 1'b1;
    for (int n = 1; n <= 170; n++) begin
      step();
      if (n == 5) start = 1'b0;
    end
    check("midreset busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    check("midreset txd", 64'(txd), 64'd1);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset ram_addr", 64'(ram_addr), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    reset = 1'b0;
    quiet = 1'b1;
    repeat (60) begin
      step();
      if (busy || done || !txd) quiet = 1'b0;
    end
    check("midreset quiet", 64'(quiet), 64'd1);
    do_dump(vecs[0], "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
